// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR amplitude envelope with a 16-bit level accumulator
// and a two-stage multiply that scales an offset-binary sample about its midpoint.
module adsr_envelope #(
  parameter int BITDEPTH = 12
) (
  input  logic                sample_clock,
  input  logic                reset_n,
  input  logic                gate,
  input  logic [7:0]          attack,
  input  logic [7:0]          decay,
  input  logic [7:0]          sustain,
  input  logic [7:0]          release_step,
  input  logic [BITDEPTH-1:0] voice_in,
  output logic [BITDEPTH-1:0] out,
  output logic [7:0]          env,
  output logic                active
);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  localparam int PW = BITDEPTH + 9;
  localparam logic [BITDEPTH-1:0] MIDPOINT = {1'b1, {(BITDEPTH-1){1'b0}}};

  state_t                  state;
  logic [15:0]             level;
  logic [16:0]             attack_sum;
  logic [8:0]              decay_dec;
  logic [8:0]              release_dec;
  logic [15:0]             target;
  logic [16:0]             decay_floor;
  logic signed [BITDEPTH-1:0] centered;
  logic signed [PW-1:0]    product;

  // release_step carries the release rate because "release" is a reserved word.
  assign attack_sum  = {1'b0, level} + {9'b0, attack} + 17'd1;
  assign decay_dec   = {1'b0, decay} + 9'd1;
  assign release_dec = {1'b0, release_step} + 9'd1;
  assign target      = {sustain, 8'h00};
  assign decay_floor = {1'b0, target} + {8'b0, decay_dec};

  assign env    = level[15:8];
  assign active = (state != IDLE);

  always_ff @(posedge sample_clock) begin
    if (!reset_n) begin
      state <= IDLE;
      level <= '0;
    end else begin
      case (state)
        IDLE: begin
          level <= '0;
          if (gate) state <= ATTACK;
        end
        ATTACK: begin
          if (!gate) begin
            state <= RELEASE;
          end else if (attack_sum[16]) begin
            level <= 16'hFFFF;
            state <= DECAY;
          end else begin
            level <= attack_sum[15:0];
          end
        end
        DECAY: begin
          // level - (decay+1) <= target, rearranged to avoid a signed subtract
          if (!gate) begin
            state <= RELEASE;
          end else if ({1'b0, level} <= decay_floor) begin
            level <= target;
            state <= SUSTAIN;
          end else begin
            level <= level - {7'b0, decay_dec};
          end
        end
        SUSTAIN: begin
          if (!gate) state <= RELEASE;
          else       level <= target;
        end
        RELEASE: begin
          if (gate) begin
            state <= ATTACK;
          end else if (level <= {7'b0, release_dec}) begin
            level <= '0;
            state <= IDLE;
          end else begin
            level <= level - {7'b0, release_dec};
          end
        end
        default: begin
          state <= IDLE;
          level <= '0;
        end
      endcase
    end
  end

  // Flipping the MSB recentres offset binary to two's complement.
  assign centered = {~voice_in[BITDEPTH-1], voice_in[BITDEPTH-2:0]};

  always_ff @(posedge sample_clock) begin
    if (!reset_n) begin
      product <= '0;
      out     <= MIDPOINT;
    end else begin
      product <= PW'(centered) * PW'($signed({1'b0, level[15:8]}));
      out     <= BITDEPTH'(product >>> 8) + MIDPOINT;
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: table vectors, hand sequences and random stimulus checked
// against an arithmetic envelope model.
module tb_adsr_envelope;

  localparam int BITDEPTH = 12;
  localparam int P_IDLE = 0, P_ATTACK = 1, P_DECAY = 2, P_SUSTAIN = 3, P_RELEASE = 4;

  logic                sample_clock = 1'b0;
  logic                reset_n;
  logic                gate;
  logic [7:0]          attack, decay, sustain, release_step;
  logic [BITDEPTH-1:0] voice_in;
  logic [BITDEPTH-1:0] out;
  logic [7:0]          env;
  logic                active;

  int vectors = 0;
  int miscompares = 0;

  int m_phase, m_level, m_p, m_out;

  typedef struct {
    logic [BITDEPTH-1:0] vin;
    logic [BITDEPTH-1:0] exp_out;
    logic [7:0]          exp_env;
    logic                exp_active;
  } vec_t;

  vec_t idle_vecs[4];
  vec_t full_vecs[7];

  adsr_envelope #(.BITDEPTH(BITDEPTH)) dut (
    .sample_clock(sample_clock),
    .reset_n(reset_n),
    .gate(gate),
    .attack(attack),
    .decay(decay),
    .sustain(sustain),
    .release_step(release_step),
    .voice_in(voice_in),
    .out(out),
    .env(env),
    .active(active)
  );

  always #5 sample_clock = ~sample_clock;

  function automatic int floor_div256(input int x);
    int q;
    q = x / 256;
    if (x < 0 && (x % 256) != 0) q = q - 1;
    return q;
  endfunction

  // One sample period of the envelope, written from the phase rules.
  task automatic model_edge();
    int a, d, r, tgt, nxt_p, nxt_out;
    if (!reset_n) begin
      m_phase = P_IDLE; m_level = 0; m_p = 0; m_out = 2048;
      return;
    end
    a = int'(attack); d = int'(decay); r = int'(release_step);
    tgt = int'(sustain) * 256;
    nxt_p   = (int'(voice_in) - 2048) * (m_level / 256);
    nxt_out = floor_div256(m_p) + 2048;
    case (m_phase)
      P_IDLE: begin
        m_level = 0;
        if (gate) m_phase = P_ATTACK;
      end
      P_ATTACK: begin
        if (!gate) m_phase = P_RELEASE;
        else if (m_level + a + 1 > 65535) begin m_level = 65535; m_phase = P_DECAY; end
        else m_level = m_level + a + 1;
      end
      P_DECAY: begin
        if (!gate) m_phase = P_RELEASE;
        else if (m_level - (d + 1) <= tgt) begin m_level = tgt; m_phase = P_SUSTAIN; end
        else m_level = m_level - (d + 1);
      end
      P_SUSTAIN: begin
        if (!gate) m_phase = P_RELEASE;
        else m_level = tgt;
      end
      default: begin
        if (gate) m_phase = P_ATTACK;
        else if (m_level <= r + 1) begin m_level = 0; m_phase = P_IDLE; end
        else m_level = m_level - (r + 1);
      end
    endcase
    m_p = nxt_p;
    m_out = nxt_out;
  endtask

  task automatic check_output(input string name);
    logic [7:0]          e_env;
    logic                e_act;
    logic [BITDEPTH-1:0] e_out;
    e_env = 8'(m_level >> 8);
    e_act = (m_phase != P_IDLE);
    e_out = BITDEPTH'(m_out);
    vectors++;
    if (env !== e_env || active !== e_act || out !== e_out) begin
      miscompares++;
      $display("[TB] FAIL %s: got env=%0d active=%0d out=%0d, want env=%0d active=%0d out=%0d",
               name, env, active, out, e_env, e_act, e_out);
    end
  endtask

  task automatic check_value(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge sample_clock);
    #1;
    check_output("model");
  endtask

  task automatic apply_stimulus(input logic g, input logic [7:0] a, input logic [7:0] d,
                                input logic [7:0] s, input logic [7:0] r);
    gate = g; attack = a; decay = d; sustain = s; release_step = r;
  endtask

  task automatic run_until(input logic [15:0] lvl, input int bound, output int n);
    n = 0;
    while (dut.level !== lvl && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    idle_vecs = '{
      '{12'd0,    12'd2048, 8'd0, 1'b0},
      '{12'd4095, 12'd2048, 8'd0, 1'b0},
      '{12'd1234, 12'd2048, 8'd0, 1'b0},
      '{12'd2048, 12'd2048, 8'd0, 1'b0}
    };
    full_vecs = '{
      '{12'd4095, 12'd4087, 8'd255, 1'b1},
      '{12'd0,    12'd8,    8'd255, 1'b1},
      '{12'd2048, 12'd2048, 8'd255, 1'b1},
      '{12'd1024, 12'd1028, 8'd255, 1'b1},
      '{12'd3072, 12'd3068, 8'd255, 1'b1},
      '{12'd2049, 12'd2048, 8'd255, 1'b1},
      '{12'd2047, 12'd2047, 8'd255, 1'b1}
    };

    voice_in = 12'd2048;
    apply_stimulus(1'b0, 8'd255, 8'd255, 8'h80, 8'd255);
    do_reset();

    $display("[TB] zero envelope in IDLE");
    for (int i = 0; i < 4; i++) begin
      voice_in = idle_vecs[i].vin;
      tick();
      tick();
      check_value("idle_out", int'(out), int'(idle_vecs[i].exp_out));
      check_value("idle_env", int'(env), int'(idle_vecs[i].exp_env));
      check_value("idle_active", int'(active), int'(idle_vecs[i].exp_active));
    end

    $display("[TB] attack then decay");
    voice_in = 12'd3000;
    gate = 1'b1;
    tick();
    check_value("attack_entry_active", int'(active), 1);
    check_value("attack_entry_level", int'(dut.level), 0);
    run_until(16'hFFFF, 400, n);
    check_value("attack_edges", n, 256);
    run_until(16'h8000, 300, n);
    check_value("decay_edges", n, 128);

    $display("[TB] release");
    gate = 1'b0;
    tick();
    check_value("release_entry_level", int'(dut.level), 32'h8000);
    check_value("release_entry_active", int'(active), 1);
    n = 0;
    while (active === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check_value("release_edges", n, 128);
    check_value("release_end_level", int'(dut.level), 0);

    $display("[TB] retrigger");
    gate = 1'b1;
    run_until(16'hFFFF, 400, n);
    run_until(16'h8000, 300, n);
    gate = 1'b0;
    for (int i = 0; i < 81; i++) tick();
    check_value("retrig_setup_level", int'(dut.level), 32'h3000);
    gate = 1'b1;
    tick();
    check_value("retrig_hold_level", int'(dut.level), 32'h3000);
    tick();
    check_value("retrig_rise_level", int'(dut.level), 32'h3100);

    $display("[TB] sustain tracking");
    run_until(16'hFFFF, 400, n);
    run_until(16'h8000, 300, n);
    tick();
    sustain = 8'h40;
    tick();
    check_value("sustain_change_level", int'(dut.level), 32'h4000);
    check_value("sustain_change_env", int'(env), 32'h40);

    $display("[TB] gate toggling");
    for (int i = 0; i < 6; i++) begin
      gate = (i % 2 == 1);
      tick();
      check_value("toggle_level", int'(dut.level), 32'h4000);
    end

    $display("[TB] reset mid-attack");
    reset_n = 1'b0;
    gate = 1'b0;
    tick();
    reset_n = 1'b1;
    check_value("reset_level", int'(dut.level), 0);
    check_value("reset_out", int'(out), 2048);
    check_value("reset_active", int'(active), 0);
    tick();
    check_value("post_reset_env", int'(env), 0);
    check_value("post_reset_active", int'(active), 0);

    $display("[TB] sustain zero");
    apply_stimulus(1'b1, 8'd255, 8'd255, 8'h00, 8'd255);
    tick();
    run_until(16'hFFFF, 400, n);
    run_until(16'h0000, 400, n);
    check_value("sustain0_decay_edges", n, 256);
    for (int i = 0; i < 3; i++) tick();
    check_value("sustain0_active", int'(active), 1);

    $display("[TB] full-scale scaling");
    do_reset();
    apply_stimulus(1'b1, 8'd255, 8'd255, 8'hFF, 8'd255);
    tick();
    run_until(16'hFFFF, 400, n);
    tick();
    for (int i = 0; i < 7; i++) begin
      voice_in = full_vecs[i].vin;
      tick();
      tick();
      check_value("scale_out", int'(out), int'(full_vecs[i].exp_out));
      check_value("scale_env", int'(env), int'(full_vecs[i].exp_env));
      check_value("scale_active", int'(active), int'(full_vecs[i].exp_active));
    end

    $display("[TB] random stimulus");
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      if ($urandom_range(0, 15) == 0) attack = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) decay = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) sustain = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) release_step = 8'($urandom_range(0, 255));
      voice_in = BITDEPTH'($urandom_range(0, 4095));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Per-voice ADSR amplitude envelope that sits directly downstream of the voice oscillator. It takes the oscillator's offset-binary sample and a gate, and runs a four-phase envelope state machine with a 16-bit level accumulator. It scales the sample about its midpoint by the 8-bit envelope and registers the result for the mixer. One instance per voice, clocked at the audio sample rate.

## Interface
- BITDEPTH, 12, sample width of voice_in/out; offset binary, zero point = 2**(BITDEPTH-1)
- sample_clock  in  1  sample-rate clock; all logic on rising edge
- reset_n  in  1  synchronous reset, active low
- gate  in  1  note on (1) / note off (0), level-sensitive
- attack  in  8  attack step; level increment per sample = attack+1
- decay  in  8  decay step; decrement per sample = decay+1
- sustain  in  8  sustain level; target = {sustain, 8'h00}
- release  in  8  release step; decrement per sample = release+1
- voice_in  in  BITDEPTH  oscillator sample, offset binary
- out  out  BITDEPTH  enveloped sample, offset binary
- env  out  8  current envelope, level[15:8]
- active  out  1  high when state != IDLE

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Registers: state, level[15:0].
- Every edge evaluates the current state. Gate checks take precedence over level rules. On a gate-driven transition, level is unchanged on that edge.
- IDLE: level<=0. If gate=1, go to ATTACK.
- ATTACK: if gate=0, go to RELEASE. Else compute s = level + attack + 1 (17-bit). If s > 0xFFFF, set level<=0xFFFF and go to DECAY; else level<=s.
- DECAY: if gate=0, go to RELEASE. Else compute d = level - (decay+1) (17-bit signed). If d <= target, set level<=target and go to SUSTAIN; else level<=d.
- SUSTAIN: if gate=0, go to RELEASE. Else level<=target every edge; sustain changes take effect immediately.
- RELEASE: if gate=1, go to ATTACK (retrigger from current level, no reset to 0). Else if level <= release+1, set level<=0 and go to IDLE; else level<=level-(release+1).
- Attack starts from the current level; there are no discontinuities except SUSTAIN tracking a changed sustain input.
- Datapath, pipeline stage 1: c = voice_in - 2**(BITDEPTH-1), signed BITDEPTH bits. p = c * level[15:8], signed BITDEPTH+9 bits, registered.
- Datapath, pipeline stage 2: out <= (p >>> 8) + 2**(BITDEPTH-1). Arithmetic shift, truncate toward -inf. No saturation is needed because |p>>>8| < 2**(BITDEPTH-1).
- env and active are combinational from the registered level/state.

## Timing
- Reset (reset_n=0 at an edge): state=IDLE, level=0, p=0, out=2**(BITDEPTH-1) (2048), env=0, active=0. Reset overrides all other inputs, including mid-envelope.
- Gate-to-state latency is 1 edge. active rises the edge after gate is first sampled high in IDLE.
- voice_in/level to out latency is 2 edges: values present before edge t appear on out after edge t+1.
- Step inputs are sampled every edge and may change mid-phase; the new step applies from that edge.
- Full attack with attack=255 takes 256 edges. With attack=0 it takes 65536 edges.
- Boundary conditions:
  - sustain=0xFF: DECAY ends once level-(decay+1) <= 0xFF00.
  - sustain=0: decay ends at 0 and the state stays in SUSTAIN (active=1) until gate falls.
  - gate toggling every edge alternates the ATTACK and RELEASE transitions with no level change.

## Test plan
- Reset: drive reset_n=0 mid-ATTACK at level 0x4000, then release reset with gate=0 -> state IDLE, level 0, out=2048, env=0, active=0.
- Attack then decay: attack=255, decay=255, sustain=0x80, gate held high from IDLE.
  - Expect ATTACK 1 edge after gate, level=0xFFFF exactly 256 edges later, then DECAY.
  - SUSTAIN is reached with level=0x8000 after 128 DECAY edges.
- Release: from SUSTAIN at 0x8000, release=255, drop gate -> RELEASE next edge, level 0 and IDLE after 128 further edges, active falls with IDLE.
- Retrigger: in RELEASE at level 0x3000, raise gate -> ATTACK next edge, level continues upward from 0x3000 without a dip.
- Scaling with level=0xFFFF (env=255), checking 2-edge latency each:
  - voice_in=4095 -> out=4087.
  - voice_in=0 -> out=8.
  - voice_in=2048 -> out=2048.
- Zero envelope: any voice_in in IDLE -> out=2048. A sustain change 0x80->0x40 while in SUSTAIN -> level=0x4000 on the next edge.
